// File: rtl/uart_tx_frame.sv
// Purpose : UART transmitter; serialises one WIDTH-bit word as start, data (LSB first), optional parity, stop.
// Latency : start bit appears on TX_OUT the cycle after Data_Valid is accepted; each bit lasts Prescale cycles.
// Backpres: Data_Valid is ignored while Busy=1; there is always at least one idle-high cycle between frames.
//
// Ports:
//   Clk        oversampling clock, shared with the RX path
//   Rst        asynchronous active-low reset
//   P_Data     parallel word, captured on acceptance
//   Data_Valid send request, accepted only in IDLE
//   Par_En     append parity bit (latched on acceptance)
//   Par_Typ    0 = even, 1 = odd parity (latched on acceptance)
//   Prescale   Clk cycles per bit, 0 behaves as 1
//   TX_OUT     registered serial line, idles high
//   Busy       high while a frame is in progress
//
// Build option: define UART_TX_TWO_STOP_EN for two stop bits (STOP lasts 2*P cycles).

module uart_tx_frame #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] P_Data,
   input  logic             Data_Valid,
   input  logic             Par_En,
   input  logic             Par_Typ,
   input  logic [5:0]       Prescale,
   output logic             TX_OUT,
   output logic             Busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t           state;
   logic [5:0]       edge_cnt;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shift_reg;
   logic             par_en_q;
   logic             par_bit_q;
`ifdef UART_TX_TWO_STOP_EN
   logic             stop_second;
`endif

   logic [5:0]       last_edge;
   logic             bit_end;
   logic [WIDTH-1:0] shift_nxt;

   // Prescale of 0 behaves as 1, so the last edge index is 0 in both cases.
   assign last_edge = (Prescale == 6'd0) ? 6'd0 : (Prescale - 6'd1);
   assign bit_end   = (edge_cnt == last_edge);
   assign shift_nxt = shift_reg >> 1;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state       <= IDLE;
         edge_cnt    <= '0;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         par_en_q    <= 1'b0;
         par_bit_q   <= 1'b0;
         TX_OUT      <= 1'b1;
         Busy        <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
         stop_second <= 1'b0;
`endif
      end else begin
         // Bit-time counter runs in every non-idle state and wraps at each bit end.
         if (state != IDLE) begin
            edge_cnt <= bit_end ? 6'd0 : (edge_cnt + 6'd1);
         end

         case (state)
            IDLE: begin
               TX_OUT   <= 1'b1;
               Busy     <= 1'b0;
               edge_cnt <= '0;
               bit_cnt  <= '0;
               if (Data_Valid) begin
                  shift_reg <= P_Data;
                  par_en_q  <= Par_En;
                  // Even parity is the XOR of the word; odd parity inverts it.
                  par_bit_q <= (^P_Data) ^ Par_Typ;
                  state     <= START;
                  TX_OUT    <= 1'b0;
                  Busy      <= 1'b1;
               end
            end

            START: begin
               if (bit_end) begin
                  state  <= DATA;
                  TX_OUT <= shift_reg[0];
               end
            end

            DATA: begin
               if (bit_end) begin
                  shift_reg <= shift_nxt;
                  if (bit_cnt == CW'(WIDTH - 1)) begin
                     bit_cnt <= '0;
                     if (par_en_q) begin
                        state  <= PARITY;
                        TX_OUT <= par_bit_q;
                     end else begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                     TX_OUT  <= shift_nxt[0];
                  end
               end
            end

            PARITY: begin
               if (bit_end) begin
                  state  <= STOP;
                  TX_OUT <= 1'b1;
               end
            end

            STOP: begin
               TX_OUT <= 1'b1;
               if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
                  if (!stop_second) begin
                     stop_second <= 1'b1;
                  end else begin
                     stop_second <= 1'b0;
                     state       <= IDLE;
                     Busy        <= 1'b0;
                  end
`else
                  state <= IDLE;
                  Busy  <= 1'b0;
`endif
               end
            end

            default: begin
               state  <= IDLE;
               TX_OUT <= 1'b1;
               Busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule
